// File: rtl/spi_arbiter_if.sv
// Bundle between spi_arbiter, its two requesters and the SPI master.
// slave: arbiter side; master: requester/SPI-master side.
interface spi_arbiter_if;
    logic       req0;
    logic       req1;
    logic [7:0] data0;
    logic [7:0] data1;
    logic [1:0] mode0;
    logic [1:0] mode1;
    logic       cs;
    logic       gnt0;
    logic       gnt1;
    logic       done0;
    logic       done1;
    logic       err;
    logic       enable;
    logic [7:0] datainput;
    logic       ckp;
    logic       cph;

    modport slave (
        input  req0, req1, data0, data1, mode0, mode1, cs,
        output gnt0, gnt1, done0, done1, err, enable,
        output datainput, ckp, cph
    );

    modport master (
        output req0, req1, data0, data1, mode0, mode1, cs,
        input  gnt0, gnt1, done0, done1, err, enable,
        input  datainput, ckp, cph
    );
endinterface

// File: rtl/spi_arbiter.sv
// Round-robin arbiter sharing one SPI master between two requesters.
// Define SPI_ARBITER_TIMEOUT_EN to bound the wait for CS low in START.
module spi_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    spi_arbiter_if.slave bus
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_XFER  = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0] state_q, state_d;
    logic       ptr_q, ptr_d;
    logic [1:0] gnt_q, gnt_d;
    logic [1:0] done_q, done_d;
    logic       en_q, en_d;
    logic [7:0] data_q, data_d;
    logic [1:0] mode_q, mode_d;
    logic       win;
    logic       tmo;

    // ptr_q holds the last requester served; on contention the other wins
    assign win = (bus.req0 && bus.req1) ? ~ptr_q : bus.req1;

`ifdef SPI_ARBITER_TIMEOUT_EN
    logic [7:0] cnt_q, cnt_d;
    logic       err_q, err_d;

    assign tmo = (cnt_q + 8'd1) == 8'(TIMEOUT_CYCLES);

    always_comb begin
        cnt_d = cnt_q;
        err_d = 1'b0;
        if (state_q == S_IDLE) begin
            cnt_d = 8'd0;
        end else if (state_q == S_START) begin
            cnt_d = cnt_q + 8'd1;
            err_d = bus.cs && tmo;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= 8'd0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    assign bus.err = err_q;
`else
    assign tmo     = 1'b0;
    assign bus.err = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        gnt_d   = gnt_q;
        done_d  = 2'b00;
        en_d    = en_q;
        data_d  = data_q;
        mode_d  = mode_q;
        unique case (state_q)
            S_IDLE: begin
                if (bus.req0 || bus.req1) begin
                    state_d = S_START;
                    gnt_d   = win ? 2'b10 : 2'b01;
                    en_d    = 1'b1;
                    data_d  = win ? bus.data1 : bus.data0;
                    mode_d  = win ? bus.mode1 : bus.mode0;
                end
            end
            S_START: begin
                if (!bus.cs) begin
                    state_d = S_XFER;
                    en_d    = 1'b0;
                end else if (tmo) begin
                    state_d = S_DONE;
                    en_d    = 1'b0;
                    done_d  = gnt_q;
                end
            end
            S_XFER: begin
                if (bus.cs) begin
                    state_d = S_DONE;
                    done_d  = gnt_q;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                ptr_d   = gnt_q[1];
                gnt_d   = 2'b00;
                en_d    = 1'b0;
                data_d  = 8'd0;
                mode_d  = 2'b00;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
            ptr_q   <= 1'b1;
            gnt_q   <= 2'b00;
            done_q  <= 2'b00;
            en_q    <= 1'b0;
            data_q  <= 8'd0;
            mode_q  <= 2'b00;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            gnt_q   <= gnt_d;
            done_q  <= done_d;
            en_q    <= en_d;
            data_q  <= data_d;
            mode_q  <= mode_d;
        end
    end

    assign bus.gnt0      = gnt_q[0];
    assign bus.gnt1      = gnt_q[1];
    assign bus.done0     = done_q[0];
    assign bus.done1     = done_q[1];
    assign bus.enable    = en_q;
    assign bus.datainput = data_q;
    assign bus.ckp       = mode_q[1];
    assign bus.cph       = mode_q[0];
endmodule

// File: tb/tb_spi_arbiter.sv
// Bench for spi_arbiter: random requesters and CS timing checked
// against a transaction-level timing model.
module tb_spi_arbiter;
    localparam int T = 16;
`ifdef SPI_ARBITER_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    spi_arbiter_if bus();

    spi_arbiter #(.TIMEOUT_CYCLES(T)) dut (
        .clk_i (clk),
        .rst_ni(rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    logic [1:0] req = 2'b00;
    logic [7:0] data [2];
    logic [1:0] mode [2];
    logic       cs = 1'b1;

    assign bus.req0  = req[0];
    assign bus.req1  = req[1];
    assign bus.data0 = data[0];
    assign bus.data1 = data[1];
    assign bus.mode0 = mode[0];
    assign bus.mode1 = mode[1];
    assign bus.cs    = cs;

    int n_chk = 0;
    int n_err = 0;
    int cyc = 0;

    // transaction model: one active service at a time, timed from its grant
    bit         act = 1'b0;
    bit         pidle = 1'b1;
    bit         ptr = 1'b1;
    bit         own = 1'b0;
    bit         to = 1'b0;
    int         tg, d, L, last;
    logic [7:0] xd;
    logic [1:0] xm;
    int         ov_d = -1;
    int         ov_L = -1;
    logic [7:0] served [$];

    int p_raise = 0;
    int p_drop = 0;
    int p_keep = 0;
    bit scram = 1'b0;
    bit fresh = 1'b0;

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     tag, got, exp, cyc);
        end
    endtask

    function automatic logic [15:0] outs();
        return {bus.gnt1, bus.gnt0, bus.done1, bus.done0, bus.err,
                bus.enable, bus.datainput, bus.ckp, bus.cph};
    endfunction

    task automatic drive(int i, bit mine, bit dn);
        if (mine && dn) begin
            if (req[i] && int'($urandom_range(99, 0)) < p_keep) begin
                if (fresh) begin
                    data[i] = 8'($urandom);
                    mode[i] = 2'($urandom);
                end
            end else begin
                req[i] = 1'b0;
            end
        end else if (mine) begin
            if (scram) begin
                data[i] = 8'($urandom);
                mode[i] = 2'($urandom);
            end
            if (req[i] && int'($urandom_range(99, 0)) < p_drop)
                req[i] = 1'b0;
        end else if (!req[i] && int'($urandom_range(99, 0)) < p_raise) begin
            req[i]  = 1'b1;
            data[i] = 8'($urandom);
            mode[i] = 2'($urandom);
        end
    endtask

    task automatic step();
        int k;
        bit dn;
        logic [1:0] eg, ed;
        logic ee, een;
        logic [7:0] edat;
        logic [1:0] em;
        @(posedge clk);
        #1;
        cyc++;
        if (!act && pidle && req != 2'b00) begin
            own  = (req == 2'b11) ? ~ptr : req[1];
            act  = 1'b1;
            tg   = cyc;
            xd   = data[own];
            xm   = mode[own];
            if (ov_d >= 0) d = ov_d;
            else if ($urandom_range(7, 0) == 0) d = int'($urandom_range(24, 6));
            else d = int'($urandom_range(5, 0));
            L    = (ov_L >= 1) ? ov_L : int'($urandom_range(6, 1));
            ov_d = -1;
            ov_L = -1;
            to   = TO_EN && d >= T;
            last = to ? T : d + L + 1;
            served.push_back(xd);
        end
        pidle = !act;
        eg = 2'b00; ed = 2'b00; ee = 1'b0; een = 1'b0;
        edat = 8'h00; em = 2'b00; k = 0; dn = 1'b0;
        if (act) begin
            k    = cyc - tg;
            eg   = 2'b01 << own;
            een  = to ? (k < T) : (k <= d);
            edat = xd;
            em   = xm;
            dn   = (k == last);
            ed   = dn ? eg : 2'b00;
            ee   = dn && to;
        end
        check("gnt", {bus.gnt1, bus.gnt0}, eg);
        check("done", {bus.done1, bus.done0}, ed);
        check("err", bus.err, ee);
        check("enable", bus.enable, een);
        check("datainput", bus.datainput, edat);
        check("mode", {bus.ckp, bus.cph}, em);
        cs = !(act && !to && k >= d && k < d + L);
        for (int i = 0; i < 2; i++) drive(i, act && own == 1'(i), dn);
        if (dn) begin
            act = 1'b0;
            ptr = own;
        end
    endtask

    task automatic apply_reset();
        #2 rst_n = 1'b0;
        #1;
        check("rst_async", outs(), 16'h0);
        cs = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_hold", outs(), 16'h0);
        @(negedge clk);
        cs    = 1'b1;
        rst_n = 1'b1;
        act   = 1'b0;
        ptr   = 1'b1;
        pidle = 1'b1;
    endtask

    initial begin
        data[0] = 8'h00; data[1] = 8'h00;
        mode[0] = 2'b00; mode[1] = 2'b00;
        repeat (2) @(posedge clk);
        #1;
        check("reset", outs(), 16'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // single request, CS low 3 cycles after ENABLE for 34 cycles
        req[0] = 1'b1; data[0] = 8'hA5; mode[0] = 2'b10;
        ov_d = 3; ov_L = 34;
        repeat (45) step();

        // owner's data changes mid-transfer
        req[0] = 1'b1; data[0] = 8'h3C; mode[0] = 2'b01;
        ov_d = 1; ov_L = 5;
        step();
        data[0] = 8'hFF;
        repeat (14) step();

        // CS never falls within the timeout window
        req[0] = 1'b1; data[0] = 8'h77; mode[0] = 2'b11;
        ov_d = T + 4; ov_L = 2;
        repeat (30) step();

        // both requesting from reset: strict alternation
        req = 2'b11; data[0] = 8'h11; data[1] = 8'h22;
        p_keep = 100;
        apply_reset();
        served.delete();
        for (int i = 0; i < 200 && served.size() < 3; i++) step();
        check("rr_count", served.size() >= 3, 1);
        check("rr_first", served.size() > 0 ? served[0] : 8'h0, 8'h11);
        check("rr_second", served.size() > 1 ? served[1] : 8'h0, 8'h22);
        check("rr_third", served.size() > 2 ? served[2] : 8'h0, 8'h11);

        // random traffic
        p_raise = 30; p_drop = 10; p_keep = 40;
        scram = 1'b1; fresh = 1'b1;
        repeat (3000) step();

        // drain, then reset in the middle of XFER
        p_raise = 0; p_drop = 0; p_keep = 0;
        for (int i = 0; i < 300 && (act || req != 2'b00); i++) step();
        check("drain", {act, req}, 3'b000);
        req[0] = 1'b1; data[0] = 8'hC3;
        ov_d = 1; ov_L = 20;
        for (int i = 0; i < 10 && !(act && cyc - tg >= 4); i++) step();
        check("in_xfer", {bus.gnt0, bus.enable}, 2'b10);
        req = 2'b10; data[1] = 8'h5A; mode[1] = 2'b11;
        apply_reset();
        repeat (40) step();

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/spi_arbiter.md
SPI_ARBITER -- requirements
Module: spi_arbiter

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 16, cycles to wait for CS low after ENABLE; legal range 1..255.
REQ-002 CLK  input  1  single clock; all state updates on its rising edge.
REQ-003 RESET  input  1  reset, asynchronous and active-low.
REQ-004 REQ0, REQ1  input  1 each  transfer request from requester 0 / 1, level, held until that requester's DONE.
REQ-005 DATA0, DATA1  input  8 each  byte to transmit for requester 0 / 1.
REQ-006 MODE0, MODE1  input  2 each  {CKP,CPH} for requester 0 / 1.
REQ-007 CS  input  1  chip select from the SPI master; low while a transfer is in progress.
REQ-008 GNT0, GNT1  output  1 each  grant, high from start of service through its DONE cycle.
REQ-009 DONE0, DONE1  output  1 each  one-cycle completion pulse to requester 0 / 1.
REQ-010 ERR  output  1  one-cycle timeout pulse, coincident with DONEx.
REQ-011 ENABLE  output  1  start request to the SPI master.
REQ-012 DATAINPUT  output  8  byte presented to the SPI master.
REQ-013 CKP, CPH  output  1 each  clock polarity / phase presented to the SPI master.

Function
REQ-014 All outputs shall be registered; no combinational path from an input to an output.
REQ-015 States: IDLE, START, XFER, DONE.
REQ-016 IDLE: ENABLE=0, GNTx=0, DATAINPUT=0, CKP=0, CPH=0; if any REQ is high, go to START on the next edge.
REQ-017 Arbitration is round-robin via a 1-bit last-served pointer: when both REQs are high, the requester not last served wins; a lone request wins immediately.
REQ-018 On IDLE->START, the winner's GNT, DATA and MODE shall be latched, so GNT=1, ENABLE=1, DATAINPUT=DATAx and {CKP,CPH}=MODEx all appear exactly one cycle after REQ is sampled.
REQ-019 DATAINPUT, CKP and CPH shall hold constant from START entry until return to IDLE, regardless of changes on DATAx or MODEx.
REQ-020 START: ENABLE=1 is held; when CS=0 is sampled, go to XFER with ENABLE=0.
REQ-021 XFER: wait; when CS=1 is sampled, go to DONE.
REQ-022 DONE: DONEx=1 for exactly one cycle with GNTx still high; update pointer to x; return to IDLE.
REQ-023 A REQ deasserted after grant shall not abort the transfer; the sequence completes and DONE still pulses.
REQ-024 REQs are sampled only in IDLE; back-to-back service has a minimum gap of one IDLE cycle.
REQ-025 At most one GNT and one DONE shall be high in any cycle.

Reset
REQ-026 While RESET=0: state=IDLE, pointer=1 (requester 0 wins the first contention), timeout counter=0, and all outputs 0.
REQ-027 Reset mid-transfer shall drop ENABLE and GNT immediately, with no DONE or ERR pulse; CS activity during reset is ignored.

Configuration
REQ-028 Macro SPI_ARBITER_TIMEOUT_EN defined: an 8-bit counter clears on START entry and increments each START cycle.
REQ-029 With the macro, if the counter reaches TIMEOUT_CYCLES without CS=0: ENABLE=0, go to DONE, and pulse ERR=1 with DONEx.
REQ-030 Macro undefined: START waits indefinitely, no counter is built, and ERR is tied to 0.

Verification
REQ-031 REQ0=1, DATA0=0xA5, MODE0=2'b10; CS low 3 cycles after ENABLE, high 34 cycles later -> ENABLE/GNT0 one cycle after REQ0, DATAINPUT=0xA5, CKP=1, CPH=0, DONE0 one pulse.
REQ-032 REQ0 and REQ1 both high from reset, DATA0=0x11, DATA1=0x22 -> served 0x11 then 0x22, then 0x11 again if both remain high.
REQ-033 DATA0 changes 0x3C->0xFF during XFER -> DATAINPUT stays 0x3C until IDLE.
REQ-034 REQ1 dropped during XFER -> transfer completes and DONE1 pulses once.
REQ-035 With SPI_ARBITER_TIMEOUT_EN, TIMEOUT_CYCLES=16, CS held high -> ENABLE drops after 16 START cycles, with ERR=1 and DONE0=1 in the same cycle.
REQ-036 RESET=0 asserted in XFER -> all outputs 0 asynchronously; after release, a new REQ1 is granted normally.
